// File: rtl/lcd_writer.sv
// HD44780 character LCD writer: power-up wait, fixed init sequence, then one
// bus-timed write per accepted LCD_WR strobe. Dropped strobes set OVERRUN.
module lcd_writer #(
   parameter int unsigned T_PWRUP = 750000,
   parameter int unsigned T_SETUP = 2,
   parameter int unsigned T_EN    = 12,
   parameter int unsigned T_HOLD  = 2,
   parameter int unsigned T_CMD   = 2000,
   parameter int unsigned T_CLR   = 82000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        LCD_WR,
   input  logic [15:0] LCD_DATA,
   input  logic        CLR_OVR,
   output logic        LCD_E,
   output logic        LCD_RS,
   output logic        LCD_RW,
   output logic [7:0]  LCD_DB,
   output logic        BUSY,
   output logic        OVERRUN
);

   localparam logic [19:0] C_PWRUP = 20'(T_PWRUP);
   localparam logic [19:0] C_SETUP = 20'(T_SETUP);
   localparam logic [19:0] C_EN    = 20'(T_EN);
   localparam logic [19:0] C_HOLD  = 20'(T_HOLD);
   localparam logic [19:0] C_CMD   = 20'(T_CMD);
   localparam logic [19:0] C_CLR   = 20'(T_CLR);

   typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, ENABLE, HOLD, EXEC} state_t;

   state_t      state;
   logic [19:0] cnt;
   logic [1:0]  init_idx;
   logic        init_done;
   logic [7:0]  init_cmd;
   logic [19:0] exec_len;
   logic        unused_data;

   assign LCD_RW      = 1'b0;
   assign unused_data = ^LCD_DATA[15:9];

   always_comb begin
      init_cmd = 8'h06;
      case (init_idx)
         2'd0:    init_cmd = 8'h38;
         2'd1:    init_cmd = 8'h0C;
         2'd2:    init_cmd = 8'h01;
         default: init_cmd = 8'h06;
      endcase
   end

   // Clear and home need the long execution wait; everything else the short one.
   always_comb begin
      exec_len = C_CMD;
      if (!LCD_RS && (LCD_DB == 8'h01 || LCD_DB == 8'h02))
         exec_len = C_CLR;
   end

   // The counter is loaded with a state's length on entry and the state is left
   // in the cycle it reads 1, so each state lasts exactly its parameter.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= PWRUP;
         cnt       <= C_PWRUP;
         init_idx  <= '0;
         init_done <= 1'b0;
         LCD_E     <= 1'b0;
         LCD_RS    <= 1'b0;
         LCD_DB    <= '0;
         BUSY      <= 1'b1;
         OVERRUN   <= 1'b0;
      end else begin
         if (LCD_WR && BUSY)
            OVERRUN <= 1'b1;
         else if (CLR_OVR)
            OVERRUN <= 1'b0;

         case (state)
            PWRUP: begin
               if (cnt == 20'd1) state <= INIT;
               else              cnt   <= cnt - 20'd1;
            end
            INIT: begin
               LCD_RS <= 1'b0;
               LCD_DB <= init_cmd;
               cnt    <= C_SETUP;
               state  <= SETUP;
            end
            IDLE: begin
               if (LCD_WR) begin
                  LCD_RS <= LCD_DATA[8];
                  LCD_DB <= LCD_DATA[7:0];
                  cnt    <= C_SETUP;
                  BUSY   <= 1'b1;
                  state  <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == 20'd1) begin
                  LCD_E <= 1'b1;
                  cnt   <= C_EN;
                  state <= ENABLE;
               end else cnt <= cnt - 20'd1;
            end
            ENABLE: begin
               if (cnt == 20'd1) begin
                  LCD_E <= 1'b0;
                  cnt   <= C_HOLD;
                  state <= HOLD;
               end else cnt <= cnt - 20'd1;
            end
            HOLD: begin
               if (cnt == 20'd1) begin
                  cnt   <= exec_len;
                  state <= EXEC;
               end else cnt <= cnt - 20'd1;
            end
            EXEC: begin
               if (cnt == 20'd1) begin
                  if (!init_done && init_idx != 2'd3) begin
                     init_idx <= init_idx + 2'd1;
                     state    <= INIT;
                  end else begin
                     init_done <= 1'b1;
                     BUSY      <= 1'b0;
                     state     <= IDLE;
                  end
               end else cnt <= cnt - 20'd1;
            end
            default: begin
               state <= PWRUP;
               cnt   <= C_PWRUP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_writer.sv
// Randomized self-checking bench for lcd_writer; expected timing and bus
// contents are derived from the write rules, not from the RTL state machine.
module tb_lcd_writer;

   localparam int unsigned P_PWRUP = 20;
   localparam int unsigned P_SETUP = 2;
   localparam int unsigned P_EN    = 4;
   localparam int unsigned P_HOLD  = 2;
   localparam int unsigned P_CMD   = 10;
   localparam int unsigned P_CLR   = 50;
   localparam int unsigned P_BUS   = P_SETUP + P_EN + P_HOLD;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        LCD_WR = 1'b0;
   logic [15:0] LCD_DATA = '0;
   logic        CLR_OVR = 1'b0;
   logic        LCD_E, LCD_RS, LCD_RW, BUSY, OVERRUN;
   logic [7:0]  LCD_DB;

   int unsigned n_checks = 0;
   int unsigned n_err = 0;
   logic        exp_ovr = 1'b0;
   logic [7:0]  exp_cmd [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

   lcd_writer #(
      .T_PWRUP(P_PWRUP), .T_SETUP(P_SETUP), .T_EN(P_EN),
      .T_HOLD(P_HOLD), .T_CMD(P_CMD), .T_CLR(P_CLR)
   ) dut (
      .CLK(CLK), .RESET(RESET), .LCD_WR(LCD_WR), .LCD_DATA(LCD_DATA),
      .CLR_OVR(CLR_OVR), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
      .LCD_DB(LCD_DB), .BUSY(BUSY), .OVERRUN(OVERRUN)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Follows an init sequence from reset release until BUSY first drops.
   task automatic watch_init();
      logic [7:0]  dbs [8];
      logic        rss [8];
      int unsigned rise [8];
      int unsigned fall [8];
      int unsigned n = 0;
      int unsigned done_k = 0;
      logic        prev_e = 1'b0;
      for (int i = 0; i < 8; i++) begin
         dbs[i] = '0; rss[i] = 1'b1; rise[i] = 0; fall[i] = 0;
      end
      for (int unsigned k = 1; k <= 3000; k++) begin
         @(negedge CLK);
         if (k == 1) check("init_busy", BUSY, 1);
         if (LCD_E && !prev_e) begin
            if (n < 8) begin dbs[n] = LCD_DB; rss[n] = LCD_RS; rise[n] = k; end
            n++;
         end
         if (!LCD_E && prev_e && n >= 1 && n <= 8) fall[n-1] = k - 1;
         prev_e = LCD_E;
         if (!BUSY) begin done_k = k; break; end
      end
      check("init_done", done_k != 0, 1);
      check("init_pulses", n, 4);
      if (n == 4) begin
         for (int i = 0; i < 4; i++) begin
            check("init_db", dbs[i], exp_cmd[i]);
            check("init_rs", rss[i], 0);
            check("init_e_width", fall[i] - rise[i] + 1, P_EN);
         end
         check("pwrup_wait", rise[0] > P_PWRUP, 1);
         check("gap_after_38", (rise[1] - fall[0] - 1 >= P_HOLD + P_CMD + P_SETUP) &&
                               (rise[1] - fall[0] - 1 <= P_HOLD + P_CMD + P_SETUP + 1), 1);
         check("gap_after_01", (rise[3] - fall[2] - 1 >= P_HOLD + P_CLR + P_SETUP) &&
                               (rise[3] - fall[2] - 1 <= P_HOLD + P_CLR + P_SETUP + 1), 1);
         check("init_tail", done_k - fall[3] - 1, P_HOLD + P_CMD);
      end
      check("init_ovr", OVERRUN, exp_ovr);
   endtask

   // Issues one write from an idle cycle; optionally plants a second strobe
   // (with or without CLR_OVR) at cycle inj_k of the transfer.
   task automatic do_write(input logic [15:0] data, input int unsigned inj_k, input logic inj_clr);
      logic        exp_rs, rs_seen, done;
      logic [7:0]  exp_db, db_seen;
      int unsigned exp_busy, busy_cnt, e_cnt, e_first, bad;
      exp_rs   = data[8];
      exp_db   = data[7:0];
      exp_busy = P_BUS + ((!exp_rs && (exp_db == 8'h01 || exp_db == 8'h02)) ? P_CLR : P_CMD);
      busy_cnt = 0; e_cnt = 0; e_first = 0; bad = 0; done = 1'b0;
      rs_seen  = ~exp_rs; db_seen = ~exp_db;
      LCD_DATA = data;
      LCD_WR   = 1'b1;
      @(posedge CLK);
      for (int unsigned k = 1; k <= 400; k++) begin
         @(negedge CLK);
         if (k == 1 || k == inj_k + 1) begin
            LCD_WR = 1'b0; CLR_OVR = 1'b0; LCD_DATA = 16'($urandom);
         end
         if (!BUSY) begin done = 1'b1; break; end
         busy_cnt++;
         if (LCD_E) begin
            if (e_cnt == 0) begin e_first = k; rs_seen = LCD_RS; db_seen = LCD_DB; end
            e_cnt++;
         end
         if (k <= P_BUS && (LCD_DB !== exp_db || LCD_RS !== exp_rs)) bad++;
         if (k == inj_k) begin
            LCD_WR = 1'b1; CLR_OVR = inj_clr; LCD_DATA = 16'($urandom); exp_ovr = 1'b1;
         end
      end
      check("wr_done", done, 1);
      check("wr_busy_len", busy_cnt, exp_busy);
      check("wr_e_start", e_first, P_SETUP + 1);
      check("wr_e_len", e_cnt, P_EN);
      check("wr_rs", rs_seen, exp_rs);
      check("wr_db", db_seen, exp_db);
      check("wr_bus_stable", bad, 0);
      check("idle_db", LCD_DB, exp_db);
      check("idle_rs", LCD_RS, exp_rs);
      check("wr_rw", LCD_RW, 0);
      check("wr_ovr", OVERRUN, exp_ovr);
   endtask

   task automatic clr_pulse();
      CLR_OVR = 1'b1;
      @(negedge CLK);
      CLR_OVR = 1'b0;
      exp_ovr = 1'b0;
      check("ovr_clear", OVERRUN, exp_ovr);
   endtask

   initial begin
      logic [15:0] d;
      int unsigned inj;
      logic        saw_e;

      repeat (2) @(negedge CLK);
      check("rst_e", LCD_E, 0);
      check("rst_rs", LCD_RS, 0);
      check("rst_rw", LCD_RW, 0);
      check("rst_db", LCD_DB, 0);
      check("rst_busy", BUSY, 1);
      check("rst_ovr", OVERRUN, 0);
      LCD_WR = 1'b1;
      @(negedge CLK);
      LCD_WR = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
      watch_init();

      do_write(16'h0141, 0, 1'b0);
      do_write(16'h0001, 0, 1'b0);
      do_write(16'h0101, 0, 1'b0);
      do_write(16'h0002, 0, 1'b0);
      do_write(16'h0141, 5, 1'b0);
      clr_pulse();
      do_write(16'h0130, 3, 1'b1);
      clr_pulse();

      for (int i = 0; i < 16; i++) begin
         d = 16'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            d[8]   = 1'b0;
            d[7:0] = 8'($urandom_range(1, 2));
         end
         inj = ($urandom_range(0, 2) == 0) ? $urandom_range(2, P_BUS + P_CMD) : 0;
         do_write(d, inj, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(negedge CLK);
         if ($urandom_range(0, 2) == 0) clr_pulse();
      end

      LCD_DATA = 16'h0155;
      LCD_WR   = 1'b1;
      @(posedge CLK);
      saw_e = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         LCD_WR = 1'b0;
         if (LCD_E) begin saw_e = 1'b1; break; end
      end
      check("mid_saw_e", saw_e, 1);
      RESET = 1'b1;
      #1;
      check("mid_rst_e", LCD_E, 0);
      check("mid_rst_busy", BUSY, 1);
      check("mid_rst_db", LCD_DB, 0);
      check("mid_rst_ovr", OVERRUN, 0);
      exp_ovr = 1'b0;
      @(negedge CLK);
      LCD_WR = 1'b1;
      @(negedge CLK);
      LCD_WR = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
      watch_init();
      do_write(16'h0148, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
